filt_seq: RTL

FILT_SEQ -- requirements
Module: filt_seq

---
 rtl/filt_pkg.sv | 18 +
 rtl/filt_res_fifo.sv | 59 +++++
 rtl/filt_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/filt_pkg.sv
// Shared types and constants for the filter frame sequencer.
// Holds default geometry, result width, Status bit positions and the sequencer state encoding.
package filt_pkg;
  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_RES_DEPTH = 2;
  localparam int RES_W         = 16;
  localparam int STATUS_W      = 3;
  localparam int ST_OVERRUN    = 0;
  localparam int ST_OVERFLOW   = 1;
  localparam int ST_UNEXPECTED = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_WAIT
  } state_e;
endpackage

// File: rtl/filt_res_fifo.sv
// Result FIFO; head is visible combinationally, so a write appears at rd_dat one clock later.
// Writes while full are ignored unless a read pops in the same cycle; the caller flags the drop.
module filt_res_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rd_fire, wr_fire;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    empty    = (cnt_q == '0);
    full     = (cnt_q == CW'(DEPTH));
    rd_dat   = mem_q[rd_ptr_q];
    rd_fire  = rd_rdy && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still takes the write.
    wr_fire  = wr_vld && (!full || rd_fire);
    if (wr_fire) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(wr_fire) - CW'(rd_fire);
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/filt_seq.sv
// Frames a serial bit stream and strobes FILTER Offset+1 clocks after each frame end (first frame skipped).
// FILTER decodes from flops with no added latency; results queue in a FIFO, drops into a full FIFO are flagged.
module filt_seq
  import filt_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int RES_DEPTH = DEF_RES_DEPTH
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                Enable,
  input  logic                SampleIn,
  input  logic                SampleValid,
  input  logic [7:0]          Offset,
  output logic                BitIn,
  output logic                FILTER,
  input  logic                Push,
  input  logic [RES_W-1:0]    Dout,
  output logic                ResValid,
  output logic [RES_W-1:0]    ResData,
  input  logic                ResReady,
  output logic [STATUS_W-1:0] Status,
  output logic [15:0]         FrameCnt
);
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_LEN - 1);

  state_e              state_q, state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]          dly_q, dly_d;
  logic                outs_q, outs_d;
  logic                bit_in_q, bit_in_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                frame_end, strobe_due, filter_fire;
  logic                res_wr, res_pop, fifo_full, fifo_empty;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    dly_d       = dly_q;
    outs_d      = outs_q;
    bit_in_d    = bit_in_q;
    status_d    = status_q;
    frame_cnt_d = frame_cnt_q;
    frame_end   = Enable && SampleValid && (bit_cnt_q == BIT_LAST);
    strobe_due  = (state_q == S_WAIT) && (dly_q == 8'd0);
    filter_fire = strobe_due && !outs_q;
    res_pop     = ResReady && !fifo_empty;
    res_wr      = Push && outs_q;

    if (SampleValid) bit_in_d = SampleIn;
    if (Enable && SampleValid) bit_cnt_d = frame_end ? '0 : bit_cnt_q + BW'(1);
    if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;

    case (state_q)
      S_IDLE:  if (Enable) state_d = S_PRIME;
      S_PRIME: if (frame_end) state_d = S_RUN;
      S_RUN: begin
        if (frame_end) begin
          state_d = S_WAIT;
          dly_d   = Offset;
        end
      end
      S_WAIT: begin
        // A new frame end restarts the delay even if the old strobe fires this cycle.
        if (frame_end) dly_d = Offset;
        else if (strobe_due) state_d = S_RUN;
        else dly_d = dly_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (strobe_due && outs_q) status_d[ST_OVERRUN] = 1'b1;
    if (Push && !outs_q) status_d[ST_UNEXPECTED] = 1'b1;
    if (res_wr && fifo_full && !res_pop) status_d[ST_OVERFLOW] = 1'b1;
    if (res_wr) outs_d = 1'b0;
    if (filter_fire) outs_d = 1'b1;

    if (!Enable) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      dly_d     = '0;
      outs_d    = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      dly_q       <= '0;
      outs_q      <= 1'b0;
      bit_in_q    <= 1'b0;
      status_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      dly_q       <= dly_d;
      outs_q      <= outs_d;
      bit_in_q    <= bit_in_d;
      status_q    <= status_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  filt_res_fifo #(
    .DEPTH(RES_DEPTH),
    .WIDTH(RES_W)
  ) u_res_fifo (
    .core_clk(Clock),
    .arst_n  (ResetN),
    .wr_vld  (res_wr),
    .wr_dat  (Dout),
    .rd_rdy  (ResReady),
    .rd_dat  (ResData),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign BitIn    = bit_in_q;
  assign FILTER   = filter_fire;
  assign ResValid = !fifo_empty;
  assign Status   = status_q;
  assign FrameCnt = frame_cnt_q;
endmodule
